spi_reg_master: RTL and testbench

Host-side SPI master for the traffic-light configuration path. It sits directly upstream of the traffic-light top's SPI slave. A simple register-write bus (addr/wen/data) loads a command, target address and data byte. A write to the START register then launches one 16-bit SPI mode-0 frame that programs t_r_wait/t_g_wait in the slave, or reads a byte back from it.

---
 rtl/spi_reg_pkg.sv | 23 ++
 rtl/spi_reg_master_if.sv | 12 +
 rtl/spi_sclk_gen.sv | 39 +++
 rtl/spi_reg_master.sv | 161 ++++++++++++++++
 tb/tb_spi_reg_master.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the host-side SPI register master: register map,
// slave register indices, frame width and FSM state encoding.
package spi_reg_pkg;

  localparam logic [7:0] A_TX_START = 8'h00;
  localparam logic [7:0] A_TX_CMD   = 8'h01;
  localparam logic [7:0] A_TX_ADDR  = 8'h02;
  localparam logic [7:0] A_TX_DATA  = 8'h03;

  localparam logic [1:0] A_T_R_WAIT = 2'h0;
  localparam logic [1:0] A_T_G_WAIT = 2'h1;

  localparam int FRAME_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_reg_master_if.sv
// Register-write bus plus frame status between the host and spi_reg_master.
interface spi_reg_master_if;
  logic [7:0] addr;
  logic       wen;
  logic [7:0] data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;

  modport master (output addr, wen, data, input rx_data, busy, done);
  modport slave  (input addr, wen, data, output rx_data, busy, done);
endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period timer for spi_sclk: registered clock level plus rise/fall strobes
// that mark the clk cycle at whose end the level toggles. Held low when disabled.
module spi_sclk_gen #(
  parameter int SCLK_HALF = 1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF - 1);

  logic [CNT_W-1:0] cnt;
  logic             half_end;

  assign half_end = en && (cnt == CNT_LAST);
  assign rise     = half_end && !sclk;
  assign fall     = half_end && sclk;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (half_end) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// Host-side SPI mode-0 master: register bus loads CMD/ADDR/DATA, a START 0->1
// edge launches one 16-bit frame to the traffic-light slave.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int SCLK_HALF  = 1,
  parameter int GAP_HALVES = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  spi_reg_master_if.slave   bus,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_ss_n
);

  localparam int GAP_CLKS = GAP_HALVES * SCLK_HALF;
  localparam int PH_W     = $clog2(GAP_CLKS + SCLK_HALF + 1) + 1;
  localparam logic [PH_W-1:0] HALF_LAST = PH_W'(SCLK_HALF - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CLKS - 1);

  state_t            state;
  logic [PH_W-1:0]   ph_cnt;
  logic [3:0]        bit_cnt;
  logic              is_wr;
  logic              cmd_q;
  logic [6:0]        addr_q;
  logic [7:0]        data_q;
  logic              start_q;
  logic [FRAME_W-2:0] tx_sr;
  logic [7:0]        rx_sr;
  logic [7:0]        rx_data_q;
  logic              busy_q;
  logic              done_q;
  logic              launch;
  logic              sclk_en;
  logic              sclk_rise;
  logic              sclk_fall;
  logic [FRAME_W-1:0] frame;

  assign frame       = {cmd_q, addr_q, data_q};
  assign launch      = bus.wen && (bus.addr == A_TX_START) && bus.data[0] &&
                       !start_q && (state == ST_IDLE);
  assign sclk_en     = (state == ST_SHIFT);
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  spi_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (sclk_en),
    .sclk  (spi_sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else if (bus.wen) begin
      case (bus.addr)
        A_TX_START: start_q <= bus.data[0];
        A_TX_CMD:   cmd_q   <= bus.data[0];
        A_TX_ADDR:  addr_q  <= bus.data[6:0];
        A_TX_DATA:  data_q  <= bus.data;
        default:    ;
      endcase
    end
  end

  // Shift registers carry payload only; the FSM decides when their contents matter.
  always_ff @(posedge clk) begin
    if (launch) begin
      tx_sr <= frame[FRAME_W-2:0];
    end else if (sclk_fall) begin
      tx_sr <= {tx_sr[FRAME_W-3:0], 1'b0};
    end
    if (sclk_rise) begin
      rx_sr <= {rx_sr[6:0], spi_miso};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      ph_cnt    <= '0;
      bit_cnt   <= '0;
      is_wr     <= 1'b0;
      spi_ss_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state    <= ST_SETUP;
            ph_cnt   <= '0;
            bit_cnt  <= '0;
            is_wr    <= cmd_q;
            spi_ss_n <= 1'b0;
            spi_mosi <= frame[FRAME_W-1];
            busy_q   <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (ph_cnt == HALF_LAST) begin
            state  <= ST_SHIFT;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          // The 16th falling edge ends the frame; mosi keeps the last bit through HOLD.
          if (sclk_fall) begin
            if (bit_cnt == 4'd15) begin
              state  <= ST_HOLD;
              ph_cnt <= '0;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              spi_mosi <= tx_sr[FRAME_W-2];
            end
          end
        end
        ST_HOLD: begin
          if (ph_cnt == HALF_LAST) begin
            state    <= ST_GAP;
            ph_cnt   <= '0;
            spi_ss_n <= 1'b1;
            spi_mosi <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (ph_cnt == GAP_LAST) begin
            state  <= ST_IDLE;
            ph_cnt <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (!is_wr) begin
              rx_data_q <= rx_sr;
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Randomized bench for spi_reg_master with a serial slave model and a register-level reference.
module tb_spi_reg_master;
  import spi_reg_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  logic spi_sclk, spi_mosi, spi_miso, spi_ss_n;

  spi_reg_master_if bus();

  spi_reg_master #(.SCLK_HALF(1), .GAP_HALVES(2)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: register map contents and expected slave-visible effects.
  logic [7:0]  m_cmd, m_addr, m_data;
  logic        m_start;
  logic [7:0]  exp_rx;
  logic [2:0]  exp_tr, exp_tg;
  logic [15:0] exp_frame;

  // Slave model / bus monitor state.
  int          mon_rises, busy_cnt, done_cnt;
  logic [15:0] mon_frame;
  logic [7:0]  done_rx;
  logic        prev_sclk = 1'b0;
  logic        prev_ss = 1'b1;
  logic [7:0]  miso_byte = 8'h00;
  logic [2:0]  sl_tr = 3'h0;
  logic [2:0]  sl_tg = 3'h0;

  assign spi_miso = (!spi_ss_n && mon_rises >= 8 && mon_rises < 16) ?
                    miso_byte[3'(15 - mon_rises)] : 1'b0;

  always @(negedge clk) begin
    if (spi_sclk && !prev_sclk && !spi_ss_n) begin
      mon_frame = {mon_frame[14:0], spi_mosi};
      mon_rises++;
    end
    if (spi_ss_n && !prev_ss && mon_rises == 16 && mon_frame[15]) begin
      if (mon_frame[14:8] == {5'b0, A_T_R_WAIT}) sl_tr = mon_frame[2:0];
      if (mon_frame[14:8] == {5'b0, A_T_G_WAIT}) sl_tg = mon_frame[2:0];
    end
    if (bus.busy) busy_cnt++;
    if (bus.done) begin
      done_cnt++;
      done_rx = bus.rx_data;
    end
    prev_sclk = spi_sclk;
    prev_ss   = spi_ss_n;
  end

  task automatic clear_mon();
    mon_rises = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    mon_frame = 16'h0;
    done_rx   = 8'h0;
  endtask

  task automatic model_reset();
    m_cmd = 8'h0; m_addr = 8'h0; m_data = 8'h0; m_start = 1'b0; exp_rx = 8'h0;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.addr = a; bus.data = d; bus.wen = 1'b1;
    @(posedge clk); #1;
    bus.wen = 1'b0;
    case (a)
      A_TX_START: m_start = d[0];
      A_TX_CMD:   m_cmd   = d;
      A_TX_ADDR:  m_addr  = d;
      A_TX_DATA:  m_data  = d;
      default:    ;
    endcase
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic predict();
    exp_frame = {m_cmd[0], m_addr[6:0], m_data};
    if (!m_cmd[0]) exp_rx = miso_byte;
    else if (m_addr[6:0] == 7'd0) exp_tr = m_data[2:0];
    else if (m_addr[6:0] == 7'd1) exp_tg = m_data[2:0];
  endtask

  task automatic check_frame(input string name, input bit ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s done: no done pulse within bound", name); end
    checks++; if (mon_frame !== exp_frame) begin errors++; $display("FAIL %s frame: got %h want %h", name, mon_frame, exp_frame); end
    checks++; if (mon_rises !== 16) begin errors++; $display("FAIL %s rises: got %0d want 16", name, mon_rises); end
    checks++; if (busy_cnt !== 36) begin errors++; $display("FAIL %s busy_len: got %0d want 36", name, busy_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done_cnt: got %0d want 1", name, done_cnt); end
    checks++; if (done_rx !== exp_rx) begin errors++; $display("FAIL %s rx_data: got %h want %h", name, done_rx, exp_rx); end
    checks++; if (sl_tr !== exp_tr || sl_tg !== exp_tg) begin errors++; $display("FAIL %s slave_regs: got %h/%h want %h/%h", name, sl_tr, sl_tg, exp_tr, exp_tg); end
  endtask

  task automatic launch_check(input string name);
    bit ok;
    write_reg(A_TX_START, 8'h00);
    predict();
    clear_mon();
    write_reg(A_TX_START, 8'h01);
    write_reg(A_TX_START, 8'h00);
    wait_done(ok);
    check_frame(name, ok);
  endtask

  task automatic run_frame(input logic [7:0] c, a, d, mb, input string name);
    write_reg(A_TX_CMD, c);
    write_reg(A_TX_ADDR, a);
    write_reg(A_TX_DATA, d);
    miso_byte = mb;
    launch_check(name);
  endtask

  task automatic test_reset();
    bus.wen = 1'b0; bus.addr = 8'h0; bus.data = 8'h0;
    n_rst = 1'b0;
    model_reset();
    exp_tr = 3'h0; exp_tg = 3'h0;
    repeat (3) @(negedge clk);
    checks++; if (spi_ss_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_pins: got ss=%b sclk=%b mosi=%b want 1/0/0", spi_ss_n, spi_sclk, spi_mosi); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_status: got busy=%b done=%b rx=%h want 0/0/00", bus.busy, bus.done, bus.rx_data); end
    n_rst = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    #1;
    checks++; if (spi_ss_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin errors++; $display("FAIL idle_pins: got ss=%b sclk=%b mosi=%b want 1/0/0", spi_ss_n, spi_sclk, spi_mosi); end
    checks++; if (busy_cnt !== 0 || done_cnt !== 0 || mon_rises !== 0) begin errors++; $display("FAIL idle_activity: got busy=%0d done=%0d rises=%0d want 0/0/0", busy_cnt, done_cnt, mon_rises); end
  endtask

  task automatic test_write_r_wait();
    run_frame(8'h01, 8'h00, 8'h02, 8'h00, "write_r");
    checks++; if (exp_frame !== 16'h8002 || sl_tr !== 3'h2) begin errors++; $display("FAIL write_r_abs: got frame %h t_r %h want 8002 2", mon_frame, sl_tr); end
  endtask

  task automatic test_write_g_wait();
    run_frame(8'h01, 8'h01, 8'h05, 8'h00, "write_g");
    checks++; if (mon_frame !== 16'h8105 || sl_tg !== 3'h5) begin errors++; $display("FAIL write_g_abs: got frame %h t_g %h want 8105 5", mon_frame, sl_tg); end
  endtask

  task automatic test_read_back();
    run_frame(8'h00, 8'h01, 8'h00, 8'hA5, "read");
    checks++; if (done_rx !== 8'hA5) begin errors++; $display("FAIL read_abs: got %h want a5", done_rx); end
  endtask

  task automatic test_busy_protect();
    bit ok;
    logic [7:0] d2;
    write_reg(A_TX_CMD, 8'h01);
    write_reg(A_TX_ADDR, 8'h00);
    write_reg(A_TX_DATA, 8'h06);
    write_reg(A_TX_START, 8'h00);
    predict();
    clear_mon();
    write_reg(A_TX_START, 8'h01);
    repeat (8) @(posedge clk);
    write_reg(A_TX_START, 8'h00);
    write_reg(A_TX_START, 8'h01);
    d2 = 8'($urandom);
    write_reg(A_TX_DATA, d2);
    wait_done(ok);
    check_frame("busy", ok);
    repeat (60) @(negedge clk);
    #1;
    checks++; if (mon_rises !== 16 || done_cnt !== 1 || busy_cnt !== 36) begin errors++; $display("FAIL busy_no_second: got rises=%0d done=%0d busy=%0d want 16/1/36", mon_rises, done_cnt, busy_cnt); end
    launch_check("busy_next");
    checks++; if (mon_frame[7:0] !== d2) begin errors++; $display("FAIL busy_new_data: got %h want %h", mon_frame[7:0], d2); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    write_reg(A_TX_CMD, 8'h01);
    write_reg(A_TX_ADDR, 8'h01);
    write_reg(A_TX_DATA, 8'h03);
    write_reg(A_TX_START, 8'h00);
    clear_mon();
    write_reg(A_TX_START, 8'h01);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (mon_rises >= 7) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_rise7: got %0d rises want 7", mon_rises); end
    n_rst = 1'b0;
    #1;
    checks++; if (spi_ss_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_async: got ss=%b sclk=%b mosi=%b busy=%b want 1/0/0/0", spi_ss_n, spi_sclk, spi_mosi, bus.busy); end
    model_reset();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (done_cnt !== 0 || mon_rises !== 7 || bus.rx_data !== 8'h00) begin errors++; $display("FAIL mid_no_done: got done=%0d rises=%0d rx=%h want 0/7/00", done_cnt, mon_rises, bus.rx_data); end
    checks++; if (sl_tg !== exp_tg) begin errors++; $display("FAIL mid_discard: got t_g %h want %h", sl_tg, exp_tg); end
    launch_check("after_reset");
    run_frame(8'h01, 8'h01, 8'($urandom), 8'h00, "after_reset2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      write_reg(8'($urandom_range(4, 255)), 8'($urandom));
      run_frame(8'($urandom), 8'($urandom_range(0, 3)) | {$urandom_range(0, 1) == 1, 7'b0},
                8'($urandom), 8'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_write_r_wait();
    test_write_g_wait();
    test_read_back();
    test_busy_protect();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
